wb_arbiter: RTL



---
 rtl/wb_arbiter.sv | 69 ++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU pipe (port 0) and the load/mul-div unit (port 1)
// onto the single register-file write port, with a registered output and starvation guard.
module wb_arbiter #(
  parameter int unsigned XLen    = 32,
  parameter int unsigned NReg    = 32,
  parameter int unsigned MaxWait = 4,
  localparam int unsigned NRegWidth = $clog2(NReg)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 p0_valid_i,
  output logic                 p0_ready_o,
  input  logic [NRegWidth-1:0] p0_rd_i,
  input  logic [XLen-1:0]      p0_data_i,
  input  logic                 p1_valid_i,
  output logic                 p1_ready_o,
  input  logic [NRegWidth-1:0] p1_rd_i,
  input  logic [XLen-1:0]      p1_data_i,
  output logic                 rf_we_o,
  output logic [NRegWidth-1:0] rf_waddr_o,
  output logic [XLen-1:0]      rf_wdata_o,
  output logic                 p1_boost_o
);

  localparam logic [3:0] MaxCnt = 4'(MaxWait);

  logic [3:0] wait_cnt;
  logic       boost;
  logic       grant_p0;
  logic       grant_p1;

  // Handshake: a transfer happens on a port when valid && ready in the same cycle.
  // Ready never looks at the requester's own valid; sources hold valid/rd/data until accepted.
  assign boost      = (wait_cnt == MaxCnt);
  assign p1_boost_o = boost;
  assign p0_ready_o = !(boost && p1_valid_i);
  assign p1_ready_o = boost || !p0_valid_i;
  assign grant_p0   = p0_valid_i && p0_ready_o;
  assign grant_p1   = p1_valid_i && p1_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      wait_cnt   <= '0;
    end else begin
      // x0 writes still move address/data but never raise the write enable.
      if (grant_p1) begin
        rf_we_o    <= (p1_rd_i != '0);
        rf_waddr_o <= p1_rd_i;
        rf_wdata_o <= p1_data_i;
      end else if (grant_p0) begin
        rf_we_o    <= (p0_rd_i != '0);
        rf_waddr_o <= p0_rd_i;
        rf_wdata_o <= p0_data_i;
      end else begin
        rf_we_o <= 1'b0;
      end

      if (grant_p1 || !p1_valid_i) begin
        wait_cnt <= '0;
      end else if (wait_cnt != MaxCnt) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

endmodule
